pause_ce_gate: RTL and testbench
================================

// Module: pause_ce_gate
// PURPOSE
//  CPU-side end of the pause path. Consumes the pause_cpu level from the pause
//  handler and gates the CPU clock-enable so that the halt lands on an opcode-
//  fetch (M1) boundary. Returns pause_ack once the CPU is frozen. Sits between
//  the core clock-enable divider and the CPU; all logic is on clk_sys.
// PARAMETERS
//  CE_DIV        4    clk_sys cycles per cpu_ce pulse (>=2)
//  DRAIN_MAX     64   cpu_ce ticks allowed in DRAIN before a forced halt
//  RESUME_DELAY  8    clk_sys cycles between pause_req low and first cpu_ce
// PORTS
//  clk_sys      in   1  core system clock
//  reset_n      in   1  async active-low reset
//  pause_req    in   1  pause level from pause handler (active-high)
//  cpu_m1_n     in   1  CPU opcode-fetch strobe (active-low), clk_sys domain
//  vblank       in   1  video vblank; only present with PAUSE_CE_VBLANK_EN
//  cpu_ce       out  1  gated CPU clock-enable, one clk_sys pulse per tick
//  pause_ack    out  1  high while CPU is frozen (state PAUSED)
//  forced       out  1  sticky: last halt came from DRAIN timeout
// BEHAVIOUR
//  Reset values: cpu_ce=0, pause_ack=0, forced=0, state=RUN, div counter=0,
//   drain counter=0, resume counter=0.
//  Divider: div_cnt counts 0..CE_DIV-1 and wraps; it free-runs in every state
//   so CE phase is preserved across a pause. tick = (div_cnt==CE_DIV-1).
//  cpu_ce is registered: asserted the cycle after a tick when the state permits.
//  States:
//   RUN    : cpu_ce follows tick. pause_req=1 -> DRAIN, drain_cnt=0.
//   DRAIN  : cpu_ce follows tick. On a tick with cpu_m1_n=0, that tick's
//            cpu_ce is suppressed -> PAUSED, forced=0. Otherwise each tick
//            increments drain_cnt; on reaching DRAIN_MAX, the tick is suppressed
//            -> PAUSED, forced=1. pause_req drops in DRAIN -> RUN (no halt).
//   PAUSED : cpu_ce=0, pause_ack=1 (registered, first high the cycle after
//            entry). pause_req=0 -> RESUME, resume_cnt=0.
//   RESUME : cpu_ce=0, pause_ack=0. resume_cnt increments each clk_sys; at
//            RESUME_DELAY-1 -> RUN. pause_req=1 again -> PAUSED (ack back
//            next cycle, no DRAIN: CPU is still frozen on M1).
//  Simultaneous: a tick coinciding with the RUN->DRAIN transition is passed
//   (DRAIN checks begin on the next tick). M1 and the DRAIN_MAX limit on the
//   same tick -> M1 path wins, forced=0.
//  forced holds its value until the next entry to PAUSED.
//  Reset mid-operation: async clear to reset values; CPU resumes via RUN with
//   no ack handshake.
//  Counter widths: $clog2 of the maximum value + 1; no wrap in drain/resume
//   counters (they saturate at their limit).
// CONFIGURATION
//  PAUSE_CE_VBLANK_EN defined: vblank port exists. The RESUME->RUN transition
//   also requires a vblank rising edge, detected with a 1-cycle delayed copy,
//   seen at or after resume_cnt reaches RESUME_DELAY-1. This keeps the resume
//   frame-aligned. Undefined: no vblank port; resume is purely on the timer.
// TESTING
//  1 CE_DIV=4, pause_req=0: cpu_ce is high exactly 1 of every 4 cycles; ack=0.
//  2 pause_req=1, cpu_m1_n low on the 3rd tick after: 2 ce pulses pass, 3rd is
//    suppressed, pause_ack=1 the next cycle, forced=0.
//  3 pause_req=1, cpu_m1_n held high: exactly 63 ce pulses, then halt;
//    pause_ack=1, forced=1.
//  4 From PAUSED, drop pause_req: ack falls next cycle; first cpu_ce >=8 cycles
//    later and aligned to the original div phase. Raise pause_req during
//    RESUME: ack returns with no ce pulse emitted.
//  5 Assert reset_n=0 in PAUSED: cpu_ce/ack/forced go to 0 immediately. After
//    release, ce resumes with div_cnt starting from 0.
//  6 With PAUSE_CE_VBLANK_EN: release pause 100 cycles before a vblank edge.
//    No cpu_ce until the edge, then ce resumes on the next tick.

Source files
------------

// File: rtl/pause_ce_gate_if.sv
// rtl/pause_ce_gate_if.sv - pause/clock-enable handshake bundle between pause handler, CPU and gate
// Signals:
//   pause_req  pause level from the pause handler (active-high)
//   cpu_m1_n   CPU opcode-fetch strobe (active-low)
//   vblank     video vblank, present only when PAUSE_CE_VBLANK_EN is defined
//   cpu_ce     gated CPU clock-enable
//   pause_ack  high while the CPU is frozen
//   forced     sticky flag: last halt came from the drain timeout
// Modports: master drives requests and observes status; slave is the gate.
interface pause_ce_gate_if;
    logic pause_req;
    logic cpu_m1_n;
    logic cpu_ce;
    logic pause_ack;
    logic forced;
`ifdef PAUSE_CE_VBLANK_EN
    logic vblank;

    modport master (
        output pause_req, cpu_m1_n, vblank,
        input  cpu_ce, pause_ack, forced
    );
    modport slave (
        input  pause_req, cpu_m1_n, vblank,
        output cpu_ce, pause_ack, forced
    );
`else
    modport master (
        output pause_req, cpu_m1_n,
        input  cpu_ce, pause_ack, forced
    );
    modport slave (
        input  pause_req, cpu_m1_n,
        output cpu_ce, pause_ack, forced
    );
`endif
endinterface

// File: rtl/pause_ce_gate.sv
// rtl/pause_ce_gate.sv - gates the CPU clock-enable so a pause halts on an opcode-fetch boundary
// Optional feature macro: PAUSE_CE_VBLANK_EN (resume additionally waits for a vblank rising edge).
// Ports:
//   clk_sys  in  core system clock
//   reset_n  in  asynchronous active-low reset
//   bus      slave modport of pause_ce_gate_if (pause_req, cpu_m1_n, [vblank] in;
//            cpu_ce, pause_ack, forced out)
module pause_ce_gate #(
    parameter int CE_DIV       = 4,
    parameter int DRAIN_MAX    = 64,
    parameter int RESUME_DELAY = 8
) (
    input  logic            clk_sys,
    input  logic            reset_n,
    pause_ce_gate_if.slave  bus
);
    localparam int DIV_W = $clog2(CE_DIV);
    localparam int DRN_W = $clog2(DRAIN_MAX + 1);
    localparam int RES_W = (RESUME_DELAY > 1) ? $clog2(RESUME_DELAY) : 1;

    localparam logic [DIV_W-1:0] DIV_LAST  = DIV_W'(CE_DIV - 1);
    localparam logic [DRN_W-1:0] DRN_LIMIT = DRN_W'(DRAIN_MAX);
    localparam logic [DRN_W-1:0] DRN_PRE   = DRN_W'(DRAIN_MAX - 1);
    localparam logic [RES_W-1:0] RES_LAST  = RES_W'(RESUME_DELAY - 1);

    typedef enum logic [1:0] {
        ST_RUN    = 2'd0,
        ST_DRAIN  = 2'd1,
        ST_PAUSED = 2'd2,
        ST_RESUME = 2'd3
    } state_t;

    state_t           r_state;
    state_t           w_state_nxt;
    logic [DIV_W-1:0] r_div_cnt;
    logic [DRN_W-1:0] r_drain_cnt;
    logic [DRN_W-1:0] w_drain_nxt;
    logic [RES_W-1:0] r_resume_cnt;
    logic [RES_W-1:0] w_resume_nxt;
    logic             r_cpu_ce;
    logic             w_ce_nxt;
    logic             r_pause_ack;
    logic             r_forced;
    logic             w_forced_nxt;
    logic             w_tick;
    logic             w_resume_ok;

    assign w_tick = (r_div_cnt == DIV_LAST);

`ifdef PAUSE_CE_VBLANK_EN
    logic r_vblank_d;

    // A rising edge is only acted on once the timer has reached its end
    // (the counter saturates there), keeping the restart frame-aligned.
    assign w_resume_ok = bus.vblank & ~r_vblank_d;

    always_ff @(posedge clk_sys or negedge reset_n) begin
        if (!reset_n) begin
            r_vblank_d <= 1'b0;
        end else begin
            r_vblank_d <= bus.vblank;
        end
    end
`else
    assign w_resume_ok = 1'b1;
`endif

    // Divider free-runs in every state so the CE phase survives a pause.
    always_ff @(posedge clk_sys or negedge reset_n) begin
        if (!reset_n) begin
            r_div_cnt <= '0;
        end else if (w_tick) begin
            r_div_cnt <= '0;
        end else begin
            r_div_cnt <= r_div_cnt + DIV_W'(1);
        end
    end

    always_ff @(posedge clk_sys or negedge reset_n) begin
        if (!reset_n) begin
            r_state      <= ST_RUN;
            r_drain_cnt  <= '0;
            r_resume_cnt <= '0;
            r_cpu_ce     <= 1'b0;
            r_pause_ack  <= 1'b0;
            r_forced     <= 1'b0;
        end else begin
            r_state      <= w_state_nxt;
            r_drain_cnt  <= w_drain_nxt;
            r_resume_cnt <= w_resume_nxt;
            r_cpu_ce     <= w_ce_nxt;
            r_pause_ack  <= (w_state_nxt == ST_PAUSED);
            r_forced     <= w_forced_nxt;
        end
    end

    always_comb begin
        w_state_nxt  = r_state;
        w_drain_nxt  = r_drain_cnt;
        w_resume_nxt = r_resume_cnt;
        w_ce_nxt     = 1'b0;
        w_forced_nxt = r_forced;
        case (r_state)
            ST_RUN: begin
                // A tick on the same cycle as the request still passes.
                w_ce_nxt = w_tick;
                if (bus.pause_req) begin
                    w_state_nxt = ST_DRAIN;
                    w_drain_nxt = '0;
                end
            end
            ST_DRAIN: begin
                if (!bus.pause_req) begin
                    w_state_nxt = ST_RUN;
                    w_ce_nxt    = w_tick;
                end else if (w_tick) begin
                    // M1 is checked first so it wins over the timeout.
                    if (!bus.cpu_m1_n) begin
                        w_state_nxt  = ST_PAUSED;
                        w_forced_nxt = 1'b0;
                    end else if (r_drain_cnt == DRN_PRE) begin
                        w_drain_nxt  = DRN_LIMIT;
                        w_state_nxt  = ST_PAUSED;
                        w_forced_nxt = 1'b1;
                    end else begin
                        w_drain_nxt = r_drain_cnt + DRN_W'(1);
                        w_ce_nxt    = 1'b1;
                    end
                end
            end
            ST_PAUSED: begin
                if (!bus.pause_req) begin
                    w_state_nxt  = ST_RESUME;
                    w_resume_nxt = '0;
                end
            end
            ST_RESUME: begin
                // CPU is still frozen on M1, so a new request skips DRAIN.
                if (bus.pause_req) begin
                    w_state_nxt = ST_PAUSED;
                end else if (r_resume_cnt == RES_LAST) begin
                    if (w_resume_ok) begin
                        w_state_nxt = ST_RUN;
                    end
                end else begin
                    w_resume_nxt = r_resume_cnt + RES_W'(1);
                end
            end
            default: begin
                w_state_nxt = ST_RUN;
            end
        endcase
    end

    assign bus.cpu_ce    = r_cpu_ce;
    assign bus.pause_ack = r_pause_ack;
    assign bus.forced    = r_forced;
endmodule

// File: tb/tb_pause_ce_gate.sv
// tb/tb_pause_ce_gate.sv - directed self-checking bench for pause_ce_gate
module tb_pause_ce_gate;
    logic clk = 1'b0;
    logic reset_n = 1'b0;
    int   cyc;
    int   errors = 0;
    int   checks = 0;
    int   n;
    int   first;
    int   ack_cyc;
    int   ack_seen;

    pause_ce_gate_if bus_if ();

    pause_ce_gate #(
        .CE_DIV       (4),
        .DRAIN_MAX    (64),
        .RESUME_DELAY (8)
    ) dut (
        .clk_sys (clk),
        .reset_n (reset_n),
        .bus     (bus_if)
    );

    always #5 clk = ~clk;

    always @(posedge clk or negedge reset_n) begin
        if (!reset_n) cyc <= 0;
        else          cyc <= cyc + 1;
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        if (obs !== exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        @(negedge clk);
    endtask

    initial begin
        bus_if.pause_req = 1'b0;
        bus_if.cpu_m1_n  = 1'b1;
`ifdef PAUSE_CE_VBLANK_EN
        bus_if.vblank    = 1'b0;
`endif
        repeat (3) step();
        check("rst_cpu_ce", bus_if.cpu_ce, 0);
        check("rst_ack", bus_if.pause_ack, 0);
        check("rst_forced", bus_if.forced, 0);
        reset_n = 1'b1;

        // Free-running CE: one pulse per 4 cycles, first at cycle 4
        n = 0; first = -1; ack_seen = 0;
        for (int i = 0; i < 40; i++) begin
            step();
            if (bus_if.cpu_ce) begin
                n++;
                if (first < 0) first = cyc;
            end
            if (bus_if.pause_ack) ack_seen = 1;
        end
        check("run_ce_count", n, 10);
        check("run_first_ce", first, 4);
        check("run_no_ack", ack_seen, 0);

        // Pause with M1 on the third tick
        bus_if.pause_req = 1'b1;
        n = 0; ack_cyc = -1;
        for (int i = 0; i < 40; i++) begin
            step();
            if (bus_if.cpu_ce) begin
                n++;
                if (n == 2) bus_if.cpu_m1_n = 1'b0;
            end
            if (bus_if.pause_ack) begin
                ack_cyc = cyc;
                break;
            end
        end
        check("m1_ce_count", n, 2);
        check("m1_ack_cycle", ack_cyc, 52);
        check("m1_forced", bus_if.forced, 0);
        n = 0;
        for (int i = 0; i < 8; i++) begin
            step();
            if (bus_if.cpu_ce) n++;
        end
        check("paused_no_ce", n, 0);
        check("paused_ack_hold", bus_if.pause_ack, 1);

`ifndef PAUSE_CE_VBLANK_EN
        // Timed resume, then a re-pause from RESUME
        bus_if.pause_req = 1'b0;
        bus_if.cpu_m1_n  = 1'b1;
        step();
        check("resume_ack_fall", bus_if.pause_ack, 0);
        first = -1;
        for (int i = 0; i < 30; i++) begin
            step();
            if (bus_if.cpu_ce) begin
                first = cyc;
                break;
            end
        end
        check("resume_first_ce", first, 72);
        bus_if.pause_req = 1'b1;
        bus_if.cpu_m1_n  = 1'b0;
        n = 0; ack_cyc = -1;
        for (int i = 0; i < 20; i++) begin
            step();
            if (bus_if.cpu_ce) n++;
            if (bus_if.pause_ack) begin
                ack_cyc = cyc;
                break;
            end
        end
        check("repause_ack_cycle", ack_cyc, 76);
        check("repause_no_ce", n, 0);
        repeat (4) step();
        bus_if.pause_req = 1'b0;
        bus_if.cpu_m1_n  = 1'b1;
        n = 0;
        step();
        if (bus_if.cpu_ce) n++;
        check("resume2_ack_fall", bus_if.pause_ack, 0);
        step();
        if (bus_if.cpu_ce) n++;
        step();
        if (bus_if.cpu_ce) n++;
        check("resume2_ack_low", bus_if.pause_ack, 0);
        bus_if.pause_req = 1'b1;
        step();
        if (bus_if.cpu_ce) n++;
        check("resume_abort_ack", bus_if.pause_ack, 1);
        check("resume_abort_no_ce", n, 0);
`else
        // Resume waits for the vblank edge 100 cycles after release
        bus_if.pause_req = 1'b0;
        bus_if.cpu_m1_n  = 1'b1;
        n = 0;
        for (int i = 0; i < 100; i++) begin
            step();
            if (bus_if.cpu_ce) n++;
        end
        check("vblank_wait_no_ce", n, 0);
        check("vblank_wait_ack", bus_if.pause_ack, 0);
        bus_if.vblank = 1'b1;
        first = -1;
        for (int i = 0; i < 20; i++) begin
            step();
            if (bus_if.cpu_ce) begin
                first = cyc;
                break;
            end
        end
        check("vblank_first_ce", first, 164);
        bus_if.vblank = 1'b0;
`endif

        bus_if.pause_req = 1'b0;
        bus_if.cpu_m1_n  = 1'b1;
        reset_n = 1'b0;
        repeat (2) step();
        reset_n = 1'b1;

        // Request dropped during DRAIN: no halt, CE keeps running
        n = 0;
        for (int i = 0; i < 8; i++) begin
            step();
            if (bus_if.cpu_ce) n++;
        end
        check("run2_ce_count", n, 2);
        bus_if.pause_req = 1'b1;
        step();
        step();
        bus_if.pause_req = 1'b0;
        n = 0; ack_seen = 0;
        for (int i = 0; i < 10; i++) begin
            step();
            if (bus_if.cpu_ce) n++;
            if (bus_if.pause_ack) ack_seen = 1;
        end
        check("drain_abort_ce", n, 3);
        check("drain_abort_no_ack", ack_seen, 0);

        // Request on a tick cycle: that tick passes, then timeout after 63 more
        repeat (3) step();
        bus_if.pause_req = 1'b1;
        step();
        check("coincident_tick_ce", bus_if.cpu_ce, 1);
        n = 0; ack_cyc = -1;
        for (int i = 0; i < 400; i++) begin
            step();
            if (bus_if.cpu_ce) n++;
            if (bus_if.pause_ack) begin
                ack_cyc = cyc;
                break;
            end
        end
        check("timeout_ce_count", n, 63);
        check("timeout_ack_cycle", ack_cyc, 280);
        check("timeout_forced", bus_if.forced, 1);
        step();
        step();
        check("forced_hold", bus_if.forced, 1);
        bus_if.pause_req = 1'b0;
        step();
        check("forced_ack_fall", bus_if.pause_ack, 0);
        check("forced_sticky_resume", bus_if.forced, 1);
        bus_if.pause_req = 1'b1;
        step();
        check("forced_repause_ack", bus_if.pause_ack, 1);
        check("forced_repause_sticky", bus_if.forced, 1);
        step();
        step();

        // Async reset while paused
        reset_n = 1'b0;
        bus_if.pause_req = 1'b0;
        #1;
        check("async_rst_ce", bus_if.cpu_ce, 0);
        check("async_rst_ack", bus_if.pause_ack, 0);
        check("async_rst_forced", bus_if.forced, 0);
        step();
        step();
        reset_n = 1'b1;
        first = -1;
        for (int i = 0; i < 10; i++) begin
            step();
            if (bus_if.cpu_ce) begin
                first = cyc;
                break;
            end
        end
        check("post_rst_first_ce", first, 4);
        check("post_rst_ack", bus_if.pause_ack, 0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
